// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and load writeback paths onto the single register-file write port
// and tracks outstanding loads per register. Define WB_RR_ARB_EN for round-robin tie-break.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_index,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [IDX_W-1:0]  mem_index,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              ld_issue,
  input  logic [IDX_W-1:0]  ld_index,
  input  logic [IDX_W-1:0]  rs1_index,
  input  logic [IDX_W-1:0]  rs2_index,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_reg_write,
  output logic [IDX_W-1:0]  rf_write_index,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam int unsigned NREG = 1 << IDX_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  src_t              r_src;
  logic              r_wr;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              w_alu_elig;
  logic              w_mem_elig;
  logic              w_alu_gnt;
  logic              w_mem_gnt;

  // Gating with nRST keeps both readies low while reset is held.
  assign w_alu_elig = nRST && alu_valid && !r_pending[alu_index];
  assign w_mem_elig = nRST && mem_valid;

`ifdef WB_RR_ARB_EN
  src_t r_last_grant;

  always_comb begin
    w_mem_gnt = w_mem_elig && (!w_alu_elig || (r_last_grant == SRC_ALU));
    w_alu_gnt = w_alu_elig && !w_mem_gnt;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_last_grant <= SRC_ALU;
    end else if (w_mem_gnt) begin
      r_last_grant <= SRC_MEM;
    end else if (w_alu_gnt) begin
      r_last_grant <= SRC_ALU;
    end
  end
`else
  always_comb begin
    w_mem_gnt = w_mem_elig;
    w_alu_gnt = w_alu_elig && !w_mem_elig;
  end
`endif

  assign alu_ready = w_alu_gnt;
  assign mem_ready = w_mem_gnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
      r_src  <= SRC_ALU;
    end else if (w_mem_gnt) begin
      r_wr   <= (mem_index != '0);
      r_idx  <= mem_index;
      r_data <= mem_data;
      r_src  <= SRC_MEM;
    end else if (w_alu_gnt) begin
      r_wr   <= (alu_index != '0);
      r_idx  <= alu_index;
      r_data <= alu_data;
      r_src  <= SRC_ALU;
    end else begin
      r_wr   <= 1'b0;
    end
  end

  // Clear is applied before set so a same-edge set of the same index wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wr && (r_src == SRC_MEM)) begin
      w_pending_nxt[r_idx] = 1'b0;
    end
    if (ld_issue) begin
      w_pending_nxt[ld_index] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign rs1_busy       = r_pending[rs1_index];
  assign rs2_busy       = r_pending[rs2_index];
  assign rf_reg_write   = r_wr;
  assign rf_write_index = r_idx;
  assign rf_write_data  = r_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the writeback port and load scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        alu_valid;
  logic [4:0]  alu_index;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_index;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        ld_issue;
  logic [4:0]  ld_index;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_reg_write;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit        m_pend [32];
  bit        m_last_mem;
  bit        m_wr;
  bit [4:0]  m_idx;
  bit [31:0] m_data;
  bit        m_from_mem;

  regfile_wb_arbiter #(.DATA_W(32), .IDX_W(5)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data), .mem_ready(mem_ready),
    .ld_issue(ld_issue), .ld_index(ld_index),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_reg_write(rf_reg_write), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last_mem = 1'b0;
    m_wr = 1'b0; m_idx = '0; m_data = '0; m_from_mem = 1'b0;
  endfunction

  // Which source the rules pick this cycle given the current inputs.
  function automatic void model_grants(output bit ga, output bit gm);
    bit alu_ok, mem_ok;
    alu_ok = alu_valid && !m_pend[alu_index];
    mem_ok = mem_valid;
    ga = 1'b0; gm = 1'b0;
    if (alu_ok && mem_ok) begin
`ifdef WB_RR_ARB_EN
      if (m_last_mem) ga = 1'b1; else gm = 1'b1;
`else
      gm = 1'b1;
`endif
    end else if (alu_ok) ga = 1'b1;
    else if (mem_ok) gm = 1'b1;
  endfunction

  function automatic void model_edge();
    bit ga, gm;
    model_grants(ga, gm);
    if (m_wr && m_from_mem) m_pend[m_idx] = 1'b0;
    if (ld_issue && ld_index != 0) m_pend[ld_index] = 1'b1;
    if (gm) begin
      m_wr = (mem_index != 0); m_idx = mem_index; m_data = mem_data; m_from_mem = 1'b1; m_last_mem = 1'b1;
    end else if (ga) begin
      m_wr = (alu_index != 0); m_idx = alu_index; m_data = alu_data; m_from_mem = 1'b0; m_last_mem = 1'b0;
    end else m_wr = 1'b0;
  endfunction

  task automatic idle_inputs();
    alu_valid = 0; alu_index = 0; alu_data = 0;
    mem_valid = 0; mem_index = 0; mem_data = 0;
    ld_issue = 0; ld_index = 0; rs1_index = 0; rs2_index = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    alu_valid = 1; alu_index = 3; mem_valid = 1; mem_index = 4;
    ld_issue = 1; ld_index = 6; rs1_index = 6; rs2_index = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", rs1_busy, rs2_busy); end
    checks++; if (rf_reg_write !== 1'b0 || rf_write_index !== 5'd0 || rf_write_data !== 32'd0) begin
      errors++; $display("FAIL reset_rf: got wr=%b idx=%0d data=%h expected 0/0/0", rf_reg_write, rf_write_index, rf_write_data); end
    // Mid-operation reset drops the registered write and pending loads.
    do_reset();
    ld_issue = 1; ld_index = 6; rs1_index = 6;
    mem_valid = 1; mem_index = 4; mem_data = 32'hCAFE0004;
    tick();
    idle_inputs(); rs1_index = 6;
    @(negedge clk);
    checks++; if (rf_reg_write !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL pre_midreset: got wr=%b busy=%b expected 1/1", rf_reg_write, rs1_busy); end
    nRST = 1'b0;
    #1;
    checks++; if (rf_reg_write !== 1'b0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL midreset: got wr=%b busy=%b expected 0/0", rf_reg_write, rs1_busy); end
  endtask

  task automatic test_both_valid();
    bit exp_mem, prev_mem;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_index = 3; alu_data = 32'h300 + i;
      mem_valid = 1; mem_index = 4; mem_data = 32'h400 + i;
`ifdef WB_RR_ARB_EN
      exp_mem = (i % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      @(negedge clk);
      checks++; if (mem_ready !== exp_mem || alu_ready !== !exp_mem) begin
        errors++; $display("FAIL tie_grant[%0d]: got mem=%b alu=%b expected mem=%b alu=%b", i, mem_ready, alu_ready, exp_mem, !exp_mem); end
      if (i > 0) begin
        checks++; if (rf_reg_write !== 1'b1 || rf_write_index !== (prev_mem ? 5'd4 : 5'd3) || rf_write_data !== (prev_mem ? 32'h400 + i - 1 : 32'h300 + i - 1)) begin
          errors++; $display("FAIL tie_write[%0d]: got wr=%b idx=%0d data=%h expected idx=%0d", i, rf_reg_write, rf_write_index, rf_write_data, prev_mem ? 4 : 3); end
      end
      prev_mem = exp_mem;
      tick();
    end
  endtask

  task automatic test_load_hazard();
    do_reset();
    ld_issue = 1; ld_index = 7; rs1_index = 7;
    @(negedge clk);
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL ld_busy_c0: got %b expected 0", rs1_busy); end
    tick();
    ld_issue = 0;
    for (int c = 1; c <= 7; c++) begin
      mem_valid = (c == 5); mem_index = 7; mem_data = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (rs1_busy !== (c < 7)) begin errors++; $display("FAIL ld_busy_c%0d: got %b expected %b", c, rs1_busy, c < 7); end
      if (c == 5) begin
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL ld_mem_ready: got %b expected 1", mem_ready); end
      end
      if (c == 6) begin
        checks++; if (rf_reg_write !== 1'b1 || rf_write_index !== 5'd7 || rf_write_data !== 32'hDEADBEEF) begin
          errors++; $display("FAIL ld_write: got wr=%b idx=%0d data=%h expected 1/7/deadbeef", rf_reg_write, rf_write_index, rf_write_data); end
      end
      tick();
    end
  endtask

  task automatic test_waw();
    do_reset();
    ld_issue = 1; ld_index = 9;
    tick();
    ld_issue = 0;
    for (int c = 1; c <= 6; c++) begin
      alu_valid = (c <= 5); alu_index = 9; alu_data = 32'hA5A5A5A5;
      mem_valid = (c == 3); mem_index = 9; mem_data = 32'h99;
      @(negedge clk);
      if (c <= 5) begin
        checks++; if (alu_ready !== (c == 5)) begin errors++; $display("FAIL waw_alu_ready_c%0d: got %b expected %b", c, alu_ready, c == 5); end
      end
      if (c == 6) begin
        checks++; if (rf_reg_write !== 1'b1 || rf_write_index !== 5'd9 || rf_write_data !== 32'hA5A5A5A5) begin
          errors++; $display("FAIL waw_write: got wr=%b idx=%0d data=%h expected 1/9/a5a5a5a5", rf_reg_write, rf_write_index, rf_write_data); end
      end
      if (c == 5) alu_valid = 1; // held until accepted this cycle
      tick();
      if (c == 5) alu_valid = 0;
    end
  endtask

  task automatic test_x0();
    do_reset();
    alu_valid = 1; alu_index = 0; alu_data = 32'h1234;
    ld_issue = 1; ld_index = 0; rs1_index = 0;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", alu_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (rf_reg_write !== 1'b0) begin errors++; $display("FAIL x0_write: got %b expected 0", rf_reg_write); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", rs1_busy); end
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    ld_issue = 1; ld_index = 5; rs1_index = 5;
    tick();
    ld_issue = 0; mem_valid = 1; mem_index = 5; mem_data = 32'h55;
    tick();
    mem_valid = 0; ld_issue = 1; ld_index = 5;
    @(negedge clk);
    checks++; if (rf_reg_write !== 1'b1 || rf_write_index !== 5'd5) begin
      errors++; $display("FAIL coll_write: got wr=%b idx=%0d expected 1/5", rf_reg_write, rf_write_index); end
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL coll_pending: got %b expected 1", rs1_busy); end
    tick();
  endtask

  task automatic test_random();
    bit ga, gm;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 3) != 0); alu_index = 5'($urandom_range(0, 7)); alu_data = $urandom;
      mem_valid = ($urandom_range(0, 2) == 0); mem_index = 5'($urandom_range(0, 7)); mem_data = $urandom;
      ld_issue  = ($urandom_range(0, 3) == 0); ld_index = 5'($urandom_range(0, 7));
      rs1_index = 5'($urandom_range(0, 7)); rs2_index = 5'($urandom_range(0, 31));
      model_grants(ga, gm);
      @(negedge clk);
      checks++; if (alu_ready !== ga || mem_ready !== gm) begin
        errors++; $display("FAIL rnd_ready[%0d]: got alu=%b mem=%b expected alu=%b mem=%b", c, alu_ready, mem_ready, ga, gm); end
      checks++; if (rs1_busy !== m_pend[rs1_index] || rs2_busy !== m_pend[rs2_index]) begin
        errors++; $display("FAIL rnd_busy[%0d]: got %b%b expected %b%b", c, rs1_busy, rs2_busy, m_pend[rs1_index], m_pend[rs2_index]); end
      checks++; if (rf_reg_write !== m_wr) begin
        errors++; $display("FAIL rnd_wr[%0d]: got %b expected %b", c, rf_reg_write, m_wr); end
      if (m_wr) begin
        checks++; if (rf_write_index !== m_idx || rf_write_data !== m_data) begin
          errors++; $display("FAIL rnd_wdata[%0d]: got idx=%0d data=%h expected idx=%0d data=%h", c, rf_write_index, rf_write_data, m_idx, m_data); end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    idle_inputs();
    #1;
    test_reset();
    test_both_valid();
    test_load_hazard();
    test_waw();
    test_x0();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32x32 register file between the ALU writeback path and the load (memory) writeback path. Each source has a valid/ready handshake. The block arbitrates between the two and drives a registered write command into the register file. It also keeps a 32-entry scoreboard of registers with outstanding loads, so the decode stage can stall on read-after-load hazards.

## Interface
Parameters:
- DATA_W, 32, write data width
- IDX_W, 5, register index width (32 registers; x0 hard-wired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous reset, active-low
- alu_valid  in  1  ALU writeback request
- alu_index  in  IDX_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_index  in  IDX_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- ld_issue  in  1  a load was issued this cycle; marks ld_index pending
- ld_index  in  IDX_W  destination of the issued load
- rs1_index, rs2_index  in  IDX_W  decode-stage source indices
- rs1_busy, rs2_busy  out  1  source register has a pending load
- rf_reg_write  out  1  register-file write enable (registered)
- rf_write_index  out  IDX_W  register-file write index (registered)
- rf_write_data  out  DATA_W  register-file write data (registered)

## Operation
- A transfer occurs when valid && ready are both high in the same cycle. ready is combinational from valid, the index, the scoreboard and the arbitration pointer. ready never depends on ready of the other port.
- **ALU eligibility:** alu_valid && !pending[alu_index]. An ALU write to a register with a pending load is held off (WAW protection) until that bit clears.
- **Mem eligibility:** mem_valid.
- **Arbitration:** at most one grant per cycle.
  - If only one source is eligible, it is granted.
  - If both are eligible, round-robin via a 1-bit last_grant: the source not granted last wins.
  - last_grant updates only on a grant.
- **Output stage:** on a grant, the next cycle presents rf_reg_write=1 with the granted index and data.
  - A granted index of 0 is accepted (ready=1) but drives rf_reg_write=0.
  - With no grant, rf_reg_write=0 and index/data hold their previous values.
- **Scoreboard pending[31:0]:**
  - Set: ld_issue with ld_index≠0 sets pending[ld_index] at the clock edge.
  - Clear: pending[idx] clears at the edge where rf_reg_write=1, the entry came from the mem source, and rf_write_index=idx. The entry is the one taken from the mem source (tracked by a registered source flag).
  - Simultaneous set and clear of the same index: set wins.
  - pending[0] is always 0.
- **Busy outputs:** rsN_busy = pending[rsN_index], combinational from the registered scoreboard. This guarantees a cleared register already holds the load data in the register file.
- A mem writeback to a register with no pending bit is legal. It is written and causes no scoreboard change.

## Timing
- Reset values: rf_reg_write=0, rf_write_index=0, rf_write_data=0, pending=0, last_grant=ALU (so mem wins the first tie), source flag=ALU.
- Outputs during reset: alu_ready=0, mem_ready=0, rs1_busy=0, rs2_busy=0.
- Reset mid-operation drops any registered write. Pending loads are forgotten; the load unit is reset by the same nRST.
- Grant at cycle N produces rf_reg_write at N+1; the register file holds the data from the N+2 edge.
- For mem writes, the pending bit clears at the N+2 edge, and busy deasserts in cycle N+2.
- Throughput is one write per cycle, sustained.

## Configuration
- WB_RR_ARB_EN defined: round-robin tie-break as above.
- WB_RR_ARB_EN undefined: fixed priority. Mem always wins ties; last_grant is not implemented. An ALU request can wait indefinitely under back-to-back loads.

## Test plan
- **Reset, both sources valid:** reset, then alu_valid=mem_valid=1 continuously to different regs (3, 4) → grants alternate mem, alu, mem, ...; rf_reg_write=1 every cycle from the second cycle after reset release.
- **Load hazard:** ld_issue with ld_index=7 at cycle 0; rs1_index=7 → rs1_busy=1 from cycle 1. Mem writes 0xDEADBEEF to r7, granted at cycle 5 → rf_write_data=0xDEADBEEF at cycle 6; rs1_busy=0 from cycle 7.
- **WAW hold-off:** pending[9]=1 and alu_valid to r9 → alu_ready=0 until the cycle pending[9] clears, then accepted with rf_write_index=9 one cycle later.
- **x0 handling:** ALU write to r0 with data 0x1234 → alu_ready=1, rf_reg_write=0 the next cycle. ld_issue to r0 → rs1_busy stays 0 for rs1_index=0.
- **Set/clear collision:** mem write to r5 reaches the output stage in the same cycle as ld_issue with ld_index=5 → pending[5] remains 1.
- **Fixed priority:** WB_RR_ARB_EN undefined and both sources valid for 4 cycles → mem_ready=1 and alu_ready=0 in all 4 cycles.
